// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor computing A - B - Bin, LSB first, with one
//   full-subtractor cell and a registered borrow. An accepted start captures
//   the operands. WIDTH SHIFT cycles follow, then a single DONE cycle.
//
// Handshake:
//   start is sampled only while busy=0 (IDLE or DONE). A start seen in DONE
//   begins the next operation with no idle cycle in between. While busy=1,
//   start is ignored and nothing is queued. done is a one-cycle pulse. On that
//   cycle diff/bout (and ovf) carry the new result, and they hold it until the
//   next completion or reset.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   start      in   operation request
//   a, b       in   [WIDTH-1:0] minuend / subtrahend (captured on accept)
//   bin        in   initial borrow-in (captured on accept)
//   busy       out  high while bits are being processed (SHIFT)
//   done       out  one-cycle completion pulse (DONE)
//   diff       out  [WIDTH-1:0] registered difference
//   bout       out  registered final borrow-out
//   ovf        out  signed overflow flag; present only when
//                   SERIAL_SUBTRACTOR_OVF_EN is defined
//   dbg_state  out  [1:0] current FSM state (0=IDLE, 1=SHIFT, 2=DONE)
//
// Optional feature macro: SERIAL_SUBTRACTOR_OVF_EN
// ---------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  output logic             ovf,
`endif
  output logic [1:0]       dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_ovf;
`endif

  logic             w_x;
  logic             w_y;
  logic             w_d;
  logic             w_borrow_next;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  // Full-subtractor cell on the current LSBs plus the result-register update.
  // The new bit enters at the MSB, so after WIDTH shifts bit 0 of the result
  // sits at bit 0.
  always_comb begin
    w_x           = r_a_sh[0];
    w_y           = r_b_sh[0];
    w_d           = w_x ^ w_y ^ r_borrow;
    w_borrow_next = (~w_x & w_y) | (~(w_x ^ w_y) & r_borrow);
    w_last        = (r_cnt == CW'(WIDTH - 1));
    w_res_next    = r_res >> 1;
    w_res_next[WIDTH-1] = w_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_ovf    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        // IDLE and DONE both accept a new operation; that is what gives
        // back-to-back operation without a bubble.
        S_IDLE, S_DONE: begin
          if (start) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_borrow <= bin;
            r_res    <= '0;
            r_cnt    <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            r_a_msb  <= a[WIDTH-1];
            r_b_msb  <= b[WIDTH-1];
`endif
            r_busy   <= 1'b1;
            r_state  <= S_SHIFT;
          end else begin
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end
        end

        S_SHIFT: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_borrow <= w_borrow_next;
          r_res    <= w_res_next;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            // The final bit is produced this cycle. Publish straight from the
            // next-value nets so diff/bout change only on entry to DONE.
            r_diff  <= w_res_next;
            r_bout  <= w_borrow_next;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            // The last bit computed is the result MSB.
            r_ovf   <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d);
`endif
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign diff      = r_diff;
  assign bout      = r_bout;
  assign dbg_state = r_state;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  assign ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//   Directed test of serial_subtractor at WIDTH=8 and WIDTH=1. The expected
//   results are hand-computed constants. They are pushed into expected queues,
//   and a monitor pops them on every done pulse. Latency and busy length are
//   checked by the driver tasks.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT, WIDTH=8 ----------------
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       bin8 = 1'b0;
  logic       busy8, done8, bout8;
  logic [7:0] diff8;
  logic [1:0] st8;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic       ovf8;
`endif

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    .ovf(ovf8),
`endif
    .dbg_state(st8)
  );

  // ---------------- DUT, WIDTH=1 ----------------
  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       bin1 = 1'b0;
  logic       busy1, done1, bout1;
  logic [0:0] diff1;
  logic [1:0] st1;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic       ovf1;
`endif

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    .ovf(ovf1),
`endif
    .dbg_state(st1)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] exp_q[$];   // {ovf, bout, diff} for the WIDTH=8 instance
  logic [1:0] exp1_q[$];  // {bout, diff} for the WIDTH=1 instance

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("w8_unexpected_done", 32'(done8), 32'd0);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        check("w8_diff", 32'(diff8), 32'(e[7:0]));
        check("w8_bout", 32'(bout8), 32'(e[8]));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        check("w8_ovf", 32'(ovf8), 32'(e[9]));
`endif
      end
    end
    if (done1 === 1'b1) begin
      if (exp1_q.size() == 0) begin
        check("w1_unexpected_done", 32'(done1), 32'd0);
      end else begin
        logic [1:0] e1;
        e1 = exp1_q.pop_front();
        check("w1_diff", 32'(diff1), 32'(e1[0]));
        check("w1_bout", 32'(bout1), 32'(e1[1]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Returns at the negedge of the first cycle after the accepting edge.
  task automatic start_op8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    @(negedge clk);
    a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  // Called at the negedge of the first cycle after the accepting edge.
  task automatic wait_done8(input string tag);
    int cyc = 1;
    int bc = 0;
    while (done8 !== 1'b1 && cyc < 40) begin
      if (busy8 === 1'b1) bc++;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'd9);
    check({tag, "_busy_cycles"}, 32'(bc), 32'd8);
    check({tag, "_busy_in_done"}, 32'(busy8), 32'd0);
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic bin, input logic [9:0] e);
    exp_q.push_back(e);
    start_op8(a, b, bin);
    wait_done8(tag);
  endtask

  task automatic op1(input logic [2:0] v, input logic [1:0] e);
    int cyc = 1;
    exp1_q.push_back(e);
    @(negedge clk);
    a1 = v[2]; b1 = v[1]; bin1 = v[0]; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("w1_busy", 32'(busy1), 32'd1);
    while (done1 !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("w1_latency", 32'(cyc), 32'd2);
  endtask

  // Full-subtractor truth table, index = {a,b,bin}, entry = {bout,diff}.
  logic [1:0] tt1 [0:7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    tt1 = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_diff", 32'(diff8), 32'd0);
    check("rst_bout", 32'(bout8), 32'd0);
    check("rst_state", 32'(st8), 32'd0);
    check("rst_w1_busy", 32'(busy1), 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    check("rst_ovf", 32'(ovf8), 32'd0);
`endif

    // Basic operations.
    op8("op_5a_3c", 8'h5A, 8'h3C, 1'b0, {1'b0, 1'b0, 8'h1E});
    op8("op_00_01", 8'h00, 8'h01, 1'b0, {1'b0, 1'b1, 8'hFF});
    op8("op_10_10_b", 8'h10, 8'h10, 1'b1, {1'b0, 1'b1, 8'hFF});
    repeat (3) @(negedge clk);
    check("hold_diff", 32'(diff8), 32'hFF);
    check("hold_bout", 32'(bout8), 32'd1);
    check("idle_done", 32'(done8), 32'd0);

    // A start during busy is ignored. Start held into DONE runs back-to-back.
    exp_q.push_back({1'b0, 1'b0, 8'h1E});
    start_op8(8'h5A, 8'h3C, 1'b0);          // now in cycle k+1
    a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;  // sampled at edge k+1 (busy)
    @(negedge clk);                         // k+2
    start8 = 1'b0;
    repeat (6) @(negedge clk);              // k+8, last SHIFT cycle
    exp_q.push_back({1'b0, 1'b1, 8'hFE});
    a8 = 8'h03; b8 = 8'h05; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);                         // k+9, DONE
    check("b2b_done_pulse", 32'(done8), 32'd1);
    @(negedge clk);                         // k+10
    start8 = 1'b0;
    check("b2b_no_bubble", 32'(busy8), 32'd1);
    wait_done8("op_b2b");

    // Reset during the 4th SHIFT cycle aborts the operation without a done pulse.
    start_op8(8'hAA, 8'h55, 1'b0);          // k+1 = 1st SHIFT cycle
    repeat (3) @(negedge clk);              // k+4 = 4th SHIFT cycle
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_done", 32'(done8), 32'd0);
    check("abort_diff", 32'(diff8), 32'd0);
    check("abort_bout", 32'(bout8), 32'd0);
    check("abort_state", 32'(st8), 32'd0);
    repeat (12) @(negedge clk);

    op8("op_80_01", 8'h80, 8'h01, 1'b0, {1'b1, 1'b0, 8'h7F});
    op8("op_05_03", 8'h05, 8'h03, 1'b0, {1'b0, 1'b0, 8'h02});

    // Exhaustive at WIDTH=1.
    for (int i = 0; i < 8; i++) begin
      op1(3'(i), tt1[i]);
    end

    repeat (4) @(negedge clk);
    check("w8_queue_empty", 32'(exp_q.size()), 32'd0);
    check("w1_queue_empty", 32'(exp1_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
